// File: rtl/rgb_compositor.sv
// rgb_compositor: priority overlay of NUM_LAYERS colour layers over BG, 2-cycle latency, accepts a pixel every cycle (no backpressure).
// Define RGB_COMPOSITOR_BLINK_EN to add the per-layer BLINK mask register (cfg_addr NUM_LAYERS+1) and frame counter.
module rgb_compositor #(
  parameter int NUM_LAYERS = 5,
  parameter int COLOR_W    = 12,
  parameter int BLINK_DIV  = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            vidon,
  input  logic [NUM_LAYERS-1:0]           layer_on,
  input  logic [1:0]                      sync_in,
  input  logic                            frame_start,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_LAYERS+2)-1:0] cfg_addr,
  input  logic [COLOR_W-1:0]              cfg_wdata,
  output logic [COLOR_W-1:0]              rgb,
  output logic [1:0]                      sync_out
);
  localparam int AW = $clog2(NUM_LAYERS+2);

  // Reset palette is defined for 4:4:4; other widths take it zero-extended or truncated.
  function automatic logic [COLOR_W-1:0] col_default(input int idx);
    logic [11:0] v;
    case (idx)
      0:       v = 12'h0F0;
      1:       v = 12'h999;
      2:       v = 12'hFF0;
      3:       v = 12'hF00;
      default: v = 12'hFFF;
    endcase
    return COLOR_W'(v);
  endfunction

  logic [COLOR_W-1:0]    r_col [NUM_LAYERS];
  logic [COLOR_W-1:0]    r_bg;
  logic [NUM_LAYERS-1:0] w_mask;
  logic [NUM_LAYERS-1:0] r_layer1;
  logic                  r_vid1;
  logic [1:0]            r_sync1;
  logic [COLOR_W-1:0]    w_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) r_col[i] <= col_default(i);
      r_bg <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_LAYERS; i++)
        if (cfg_addr == AW'(i)) r_col[i] <= cfg_wdata;
      if (cfg_addr == AW'(NUM_LAYERS)) r_bg <= cfg_wdata;
    end
  end

`ifdef RGB_COMPOSITOR_BLINK_EN
  logic [BLINK_DIV:0]    r_frame_cnt;
  logic [NUM_LAYERS-1:0] r_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_blink     <= '0;
    end else begin
      if (frame_start) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (cfg_we && cfg_addr == AW'(NUM_LAYERS+1)) r_blink <= cfg_wdata[NUM_LAYERS-1:0];
    end
  end

  // Counter MSB high marks the "off" half of the blink period.
  assign w_mask = r_frame_cnt[BLINK_DIV] ? r_blink : '0;
`else
  logic w_unused_frame_start;
  assign w_unused_frame_start = frame_start;
  assign w_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vid1   <= 1'b0;
      r_layer1 <= '0;
      r_sync1  <= 2'b00;
    end else begin
      r_vid1   <= vidon;
      r_layer1 <= layer_on & ~w_mask;
      r_sync1  <= sync_in;
    end
  end

  // Walk from lowest priority upward so bit 0 wins.
  always_comb begin
    w_pix = r_bg;
    for (int i = NUM_LAYERS-1; i >= 0; i--)
      if (r_layer1[i]) w_pix = r_col[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb      <= '0;
      sync_out <= 2'b00;
    end else begin
      rgb      <= r_vid1 ? w_pix : '0;
      sync_out <= r_sync1;
    end
  end
endmodule

// File: tb/tb_rgb_compositor.sv
// Self-checking bench for rgb_compositor: per-cycle reference model plus hand-computed literal checks.
module tb_rgb_compositor;
  localparam int NL = 5;
  localparam int CW = 12;
  localparam int BD = 1;

  logic          clk;
  logic          rst_n;
  logic          vidon;
  logic [NL-1:0] layer_on;
  logic [1:0]    sync_in;
  logic          frame_start;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic [CW-1:0] rgb;
  logic [1:0]    sync_out;

  int total = 0;
  int bad   = 0;

  rgb_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .vidon(vidon), .layer_on(layer_on),
    .sync_in(sync_in), .frame_start(frame_start), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .rgb(rgb), .sync_out(sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pixel is a record that waits one edge in flight and is
  // resolved against the colour table as it stands just before the next edge's writes.
  typedef struct packed {
    logic          vid;
    logic [NL-1:0] lay;
    logic [1:0]    sync;
  } pix_t;

  pix_t        pipe_q[$];
  logic [11:0] m_col [0:NL-1];
  logic [11:0] m_bg;
  logic [NL-1:0] m_blink;
  int unsigned m_frames;
  logic [11:0] exp_rgb;
  logic [1:0]  exp_sync;
  logic        check_en = 1'b0;

  task automatic model_reset();
    m_col = '{12'h0F0, 12'h999, 12'hFF0, 12'hF00, 12'hFFF};
    m_bg = 12'h000;
    m_blink = '0;
    m_frames = 0;
    pipe_q.delete();
    pipe_q.push_back('0);
    exp_rgb = 12'h000;
    exp_sync = 2'b00;
  endtask

  task automatic model_edge();
    pix_t old;
    pix_t now;
    int   winner;
    logic blink_off_phase;
    old = pipe_q.pop_front();
    exp_sync = old.sync;
    winner = -1;
    for (int i = 0; i < NL; i++)
      if (old.lay[i] && winner < 0) winner = i;
    if (!old.vid)        exp_rgb = 12'h000;
    else if (winner < 0) exp_rgb = m_bg;
    else                 exp_rgb = m_col[winner];
`ifdef RGB_COMPOSITOR_BLINK_EN
    blink_off_phase = ((m_frames / (2 ** BD)) % 2) == 1;
`else
    blink_off_phase = 1'b0;
`endif
    now.vid  = vidon;
    now.lay  = blink_off_phase ? (layer_on & ~m_blink) : layer_on;
    now.sync = sync_in;
    pipe_q.push_back(now);
`ifdef RGB_COMPOSITOR_BLINK_EN
    if (frame_start) m_frames = m_frames + 1;
`endif
    if (cfg_we) begin
      if (cfg_addr < NL)       m_col[cfg_addr] = cfg_wdata;
      else if (cfg_addr == NL) m_bg = cfg_wdata;
`ifdef RGB_COMPOSITOR_BLINK_EN
      else if (cfg_addr == NL + 1) m_blink = cfg_wdata[NL-1:0];
`endif
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_edge();
  end

  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (rgb !== exp_rgb) begin
        bad++;
        $display("FAIL model_rgb t=%0t got=%h want=%h", $time, rgb, exp_rgb);
      end
      total++;
      if (sync_out !== exp_sync) begin
        bad++;
        $display("FAIL model_sync t=%0t got=%b want=%b", $time, sync_out, exp_sync);
      end
    end
  end

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [CW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  logic [11:0] blink_want;

  initial begin
    rst_n = 1'b1; vidon = 1'b0; layer_on = '0; sync_in = 2'b00;
    frame_start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #2 rst_n = 1'b0;
    #1 check_en = 1'b1;
    cyc(); cyc();
    chk("reset_rgb", rgb, 12'h000);
    chk("reset_sync", {10'd0, sync_out}, 12'h000);
    rst_n = 1'b1;

    // Default palette and priority
    vidon = 1'b1; layer_on = 5'b00110;
    cyc(); cyc();
    chk("prio_00110", rgb, 12'h999);
    layer_on = 5'b00000;
    cyc(); cyc();
    chk("bg_default", rgb, 12'h000);
    layer_on = 5'b01100;
    cyc(); cyc();
    chk("prio_01100", rgb, 12'hFF0);

    // Background and vidon blanking
    wr(3'd5, 12'h00F);
    layer_on = 5'b00000;
    cyc(); cyc();
    chk("bg_written", rgb, 12'h00F);
    vidon = 1'b0;
    cyc(); cyc();
    chk("vidon_blank", rgb, 12'h000);
    vidon = 1'b1;

    // Sync alignment
    sync_in = 2'b01; cyc();
    sync_in = 2'b10; cyc();
    chk("sync_seq0", {10'd0, sync_out}, 12'h001);
    sync_in = 2'b11; cyc();
    chk("sync_seq1", {10'd0, sync_out}, 12'h002);
    sync_in = 2'b00; cyc();
    chk("sync_seq2", {10'd0, sync_out}, 12'h003);

    // Blink: layer 0 masked in alternate 2-frame halves only when compiled in
    layer_on = 5'b00011;
    wr(3'd6, 12'h001);
    cyc(); cyc();
    chk("blink_frame0", rgb, 12'h0F0);
    for (int k = 1; k <= 8; k++) begin
      frame_start = 1'b1; cyc();
      frame_start = 1'b0; cyc(); cyc(); cyc();
`ifdef RGB_COMPOSITOR_BLINK_EN
      blink_want = (((k / 2) % 2) == 1) ? 12'h999 : 12'h0F0;
`else
      blink_want = 12'h0F0;
`endif
      chk($sformatf("blink_frame%0d", k), rgb, blink_want);
    end
    wr(3'd6, 12'h000);

    // Colour write while the layer streams: old value at edge e, new value after
    layer_on = 5'b00001;
    cyc(); cyc();
    chk("col0_before", rgb, 12'h0F0);
    wr(3'd0, 12'h123);
    chk("col0_at_write", rgb, 12'h0F0);
    cyc();
    chk("col0_after", rgb, 12'h123);

    // Out-of-range address ignored
    wr(3'd7, 12'hEEE);
    layer_on = 5'b10000;
    cyc(); cyc();
    chk("addr7_col4", rgb, 12'hFFF);
    layer_on = 5'b00000;
    cyc(); cyc();
    chk("addr7_bg", rgb, 12'h00F);

    // Mid-stream reset restores defaults
    wr(3'd1, 12'hABC);
    layer_on = 5'b00010;
    cyc(); cyc();
    chk("col1_custom", rgb, 12'hABC);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_rgb", rgb, 12'h000);
    chk("rst_async_sync", {10'd0, sync_out}, 12'h000);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("rst_col1_default", rgb, 12'h999);
    layer_on = 5'b00001;
    cyc(); cyc();
    chk("rst_col0_default", rgb, 12'h0F0);
    layer_on = 5'b00000;
    cyc(); cyc();
    chk("rst_bg_default", rgb, 12'h000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      vidon       = ($urandom_range(0, 3) != 0);
      layer_on    = NL'($urandom);
      sync_in     = 2'($urandom);
      frame_start = ($urandom_range(0, 7) == 0);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_addr    = 3'($urandom_range(0, 7));
      cfg_wdata   = CW'($urandom);
      cyc();
    end
    cfg_we = 1'b0; frame_start = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
